// File: rtl/fetch_bus_subunit_if.sv
// fetch_bus_subunit_if: fetch-side request/response signals plus the
// instruction-bus read channel of the fetch bus sub-unit.
//   new_request  fetch issues a request this cycle
//   stage1_addr  request address in the new_request cycle
//   stage2_addr  request address registered by fetch, valid the next cycle
//   flush        abort the outstanding request
//   ready        sub-unit can accept new_request
//   data_valid   one-cycle pulse, data_out holds the instruction
//   data_out     fetched instruction
//   bus_req      bus read request, held until bus_ack (or timeout)
//   bus_addr     word-aligned bus read address
//   bus_ack      bus read complete, bus_rdata valid
//   bus_rdata    bus read data
// slave modport: the sub-unit view; master modport: the fetch/bus view.
interface fetch_bus_subunit_if;
    localparam int unsigned XLEN = 32;

    logic            new_request;
    logic [XLEN-1:0] stage1_addr;
    logic [XLEN-1:0] stage2_addr;
    logic            flush;
    logic            ready;
    logic            data_valid;
    logic [XLEN-1:0] data_out;
    logic            bus_req;
    logic [XLEN-1:0] bus_addr;
    logic            bus_ack;
    logic [XLEN-1:0] bus_rdata;

    modport slave (
        input  new_request, stage1_addr, stage2_addr, flush, bus_ack, bus_rdata,
        output ready, data_valid, data_out, bus_req, bus_addr
    );

    modport master (
        output new_request, stage1_addr, stage2_addr, flush, bus_ack, bus_rdata,
        input  ready, data_valid, data_out, bus_req, bus_addr
    );
endinterface

// File: rtl/fetch_bus_subunit.sv
// fetch_bus_subunit: turns one fetch request into one instruction-bus read and
// returns the word as a single data_valid pulse. Flushes abort the request;
// a read already on the bus is drained silently before going idle.
// Ports:
//   clk   sole clock, rising edge
//   rst   asynchronous active-high reset
//   fbus  fetch_bus_subunit_if.slave (request, response and bus channels)
// Parameters:
//   TIMEOUT_CYCLES  cycles in BUS_WAIT/DRAIN before abandoning a read (2..1023)
//   TIMEOUT_INSTR   word returned on a timeout (NOP)
// Optional feature: define FETCH_BUS_SUBUNIT_TIMEOUT_EN to enable the read
// timeout; without it the unit waits indefinitely for bus_ack.
module fetch_bus_subunit #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] TIMEOUT_INSTR  = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      rst,
    fetch_bus_subunit_if.slave        fbus
);
    localparam int unsigned XLEN = 32;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("fetch_bus_subunit: TIMEOUT_CYCLES must be in 2..1023");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUS_WAIT,
        DRAIN
    } state_t;

    state_t            state;
    logic              ready_q;
    logic              data_valid_q;
    logic [XLEN-1:0]   data_out_q;
    logic              bus_req_q;
    logic [XLEN-1:0]   addr_q;
    logic              first_q;
    logic [XLEN-1:0]   s1_q;
    logic              timeout_hit;

    // stage2_addr only becomes valid in the first BUS_WAIT cycle, so that cycle
    // drives the bus straight from it; the aligned value is held afterwards.
    assign fbus.bus_addr   = first_q ? {fbus.stage2_addr[XLEN-1:2], 2'b00} : addr_q;
    assign fbus.ready      = ready_q;
    assign fbus.data_valid = data_valid_q;
    assign fbus.data_out   = data_out_q;
    assign fbus.bus_req    = bus_req_q;

`ifdef FETCH_BUS_SUBUNIT_TIMEOUT_EN
    localparam int unsigned CNT_W = 10;
    logic [CNT_W-1:0] cnt;

    // Held at zero in IDLE so it starts from zero on entry to BUS_WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (state != IDLE) && !fbus.bus_ack &&
                         (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Request state machine with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ready_q      <= 1'b1;
            data_valid_q <= 1'b0;
            data_out_q   <= '0;
            bus_req_q    <= 1'b0;
            addr_q       <= '0;
            first_q      <= 1'b0;
            s1_q         <= '0;
        end else begin
            data_valid_q <= 1'b0;
            first_q      <= 1'b0;

            // Fetch must present the registered copy of the stage-1 address.
            if (first_q) begin
                assert (fbus.stage2_addr == s1_q);
            end

            case (state)
                IDLE: begin
                    // A request raised together with flush is dropped.
                    if (fbus.new_request && !fbus.flush) begin
                        state     <= BUS_WAIT;
                        ready_q   <= 1'b0;
                        bus_req_q <= 1'b1;
                        first_q   <= 1'b1;
                        s1_q      <= fbus.stage1_addr;
                    end
                end

                BUS_WAIT: begin
                    if (first_q) begin
                        addr_q <= {fbus.stage2_addr[XLEN-1:2], 2'b00};
                    end
                    if (fbus.bus_ack) begin
                        state        <= IDLE;
                        ready_q      <= 1'b1;
                        bus_req_q    <= 1'b0;
                        data_out_q   <= fbus.bus_rdata;
                        data_valid_q <= !fbus.flush;
                    end else if (timeout_hit) begin
                        state        <= IDLE;
                        ready_q      <= 1'b1;
                        bus_req_q    <= 1'b0;
                        data_out_q   <= TIMEOUT_INSTR;
                        data_valid_q <= !fbus.flush;
                    end else if (fbus.flush) begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    // Flushed read: finish the bus transfer, return nothing.
                    if (fbus.bus_ack || timeout_hit) begin
                        state     <= IDLE;
                        ready_q   <= 1'b1;
                        bus_req_q <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    ready_q   <= 1'b1;
                    bus_req_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_bus_subunit.sv
// tb_fetch_bus_subunit: table-driven vectors plus hand-written sequences for
// back-to-back, flush, timeout and reset corners. Expected data words go into
// a scoreboard queue when the ack is driven and are matched on data_valid.
module tb_fetch_bus_subunit;
    localparam int unsigned TOUT = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] sb[$];

    fetch_bus_subunit_if ifc();

    fetch_bus_subunit #(
        .TIMEOUT_CYCLES(TOUT),
        .TIMEOUT_INSTR (32'h0000_0013)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fbus(ifc)
    );

    typedef struct {
        logic [31:0] addr;
        int          waits;
        logic [31:0] rdata;
        int          flush_cyc;
        logic [31:0] exp_addr;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fetch registers the stage-1 address on every request.
    always @(posedge clk) begin
        if (ifc.new_request) ifc.stage2_addr <= ifc.stage1_addr;
    end

    // New requests are only legal while the unit is ready.
    always @(posedge clk) begin
        if (!rst && ifc.new_request) assert (ifc.ready);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every data_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && ifc.data_valid) begin
            if (sb.size() == 0) begin
                chk("dv_unexpected", 32'(ifc.data_valid), 32'h0);
            end else begin
                chk("data_out", ifc.data_out, sb.pop_front());
            end
        end
    end

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        chk("ready_before", 32'(ifc.ready), 32'h1);
        ifc.new_request = 1'b1;
        ifc.stage1_addr = v.addr;
        ifc.flush       = 1'b0;
        @(negedge clk);
        ifc.new_request = 1'b0;
        for (int k = 0; k <= v.waits; k++) begin
            chk("bus_req_held", 32'(ifc.bus_req), 32'h1);
            chk("bus_addr", ifc.bus_addr, v.exp_addr);
            ifc.flush     = (v.flush_cyc == k);
            ifc.bus_ack   = (k == v.waits);
            ifc.bus_rdata = v.rdata;
            if (k == v.waits && v.exp_valid) sb.push_back(v.rdata);
            @(negedge clk);
        end
        ifc.flush   = 1'b0;
        ifc.bus_ack = 1'b0;
        chk("ready_after", 32'(ifc.ready), 32'h1);
        chk("bus_req_after", 32'(ifc.bus_req), 32'h0);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ifc.new_request = 1'b0;
        ifc.stage1_addr = '0;
        ifc.stage2_addr = '0;
        ifc.flush       = 1'b0;
        ifc.bus_ack     = 1'b0;
        ifc.bus_rdata   = '0;

        vecs[0] = '{32'h8000_0106, 3, 32'h00A0_0093, -1, 32'h8000_0104, 1'b1};
        vecs[1] = '{32'h0000_1000, 0, 32'h1234_5678, -1, 32'h0000_1000, 1'b1};
        vecs[2] = '{32'h0000_200B, 1, 32'hDEAD_BEEF, -1, 32'h0000_2008, 1'b1};
        vecs[3] = '{32'h4000_0004, 4, 32'h1111_1111,  0, 32'h4000_0004, 1'b0};
        vecs[4] = '{32'h4000_0010, 2, 32'h2222_2222,  2, 32'h4000_0010, 1'b0};
        vecs[5] = '{32'hFFFF_FFFF, 0, 32'hCAFE_F00D,  0, 32'hFFFF_FFFC, 1'b0};
        vecs[6] = '{32'h0000_0003, 2, 32'h0000_0000, -1, 32'h0000_0000, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ifc.ready), 32'h1);
        chk("rst_data_valid", 32'(ifc.data_valid), 32'h0);
        chk("rst_data_out", ifc.data_out, 32'h0);
        chk("rst_bus_req", 32'(ifc.bus_req), 32'h0);
        chk("rst_bus_addr", ifc.bus_addr, 32'h0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back: next request in the data_valid cycle, ack immediately.
        @(negedge clk);
        ifc.new_request = 1'b1;
        ifc.stage1_addr = 32'h0000_3000;
        @(negedge clk);
        chk("b2b_bus_req1", 32'(ifc.bus_req), 32'h1);
        ifc.new_request = 1'b0;
        ifc.bus_ack     = 1'b1;
        ifc.bus_rdata   = 32'hAAAA_0001;
        sb.push_back(32'hAAAA_0001);
        @(negedge clk);
        chk("b2b_dv1", 32'(ifc.data_valid), 32'h1);
        chk("b2b_ready1", 32'(ifc.ready), 32'h1);
        ifc.bus_ack     = 1'b0;
        ifc.new_request = 1'b1;
        ifc.stage1_addr = 32'h0000_3004;
        @(negedge clk);
        chk("b2b_gap", 32'(ifc.data_valid), 32'h0);
        chk("b2b_bus_addr2", ifc.bus_addr, 32'h0000_3004);
        ifc.new_request = 1'b0;
        ifc.bus_ack     = 1'b1;
        ifc.bus_rdata   = 32'hAAAA_0002;
        sb.push_back(32'hAAAA_0002);
        @(negedge clk);
        chk("b2b_dv2", 32'(ifc.data_valid), 32'h1);
        ifc.bus_ack = 1'b0;

        // Request dropped by a simultaneous flush; a stray ack is ignored.
        @(negedge clk);
        ifc.new_request = 1'b1;
        ifc.flush       = 1'b1;
        ifc.stage1_addr = 32'h0000_4000;
        @(negedge clk);
        ifc.new_request = 1'b0;
        ifc.flush       = 1'b0;
        chk("drop_bus_req", 32'(ifc.bus_req), 32'h0);
        chk("drop_ready", 32'(ifc.ready), 32'h1);
        ifc.bus_ack   = 1'b1;
        ifc.bus_rdata = 32'hBBBB_BBBB;
        @(negedge clk);
        ifc.bus_ack = 1'b0;
        chk("stray_ack_dv", 32'(ifc.data_valid), 32'h0);
        chk("stray_ack_bus_req", 32'(ifc.bus_req), 32'h0);

        // No ack at all: timeout if enabled, otherwise wait indefinitely.
        @(negedge clk);
        ifc.new_request = 1'b1;
        ifc.stage1_addr = 32'h0000_0500;
        @(negedge clk);
        ifc.new_request = 1'b0;
`ifdef FETCH_BUS_SUBUNIT_TIMEOUT_EN
        sb.push_back(32'h0000_0013);
`endif
        n = 0;
        while (ifc.bus_req && n < 100) begin
            @(negedge clk);
            n++;
        end
`ifdef FETCH_BUS_SUBUNIT_TIMEOUT_EN
        chk("timeout_len", 32'(n), 32'(TOUT));
        @(negedge clk);
        ifc.new_request = 1'b1;
        ifc.stage1_addr = 32'h0000_0600;
        @(negedge clk);
        ifc.new_request = 1'b0;
`else
        chk("no_timeout_bus_req", 32'(ifc.bus_req), 32'h1);
`endif

        // Reset in the middle of BUS_WAIT: bus_req drops at once, later ack ignored.
        chk("pre_rst_bus_req", 32'(ifc.bus_req), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_bus_req", 32'(ifc.bus_req), 32'h0);
        chk("async_rst_dv", 32'(ifc.data_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(ifc.ready), 32'h1);
        chk("post_rst_bus_req", 32'(ifc.bus_req), 32'h0);
        ifc.bus_ack   = 1'b1;
        ifc.bus_rdata = 32'hCCCC_CCCC;
        @(negedge clk);
        ifc.bus_ack = 1'b0;
        chk("post_rst_ack_dv", 32'(ifc.data_valid), 32'h0);
        chk("post_rst_ack_ready", 32'(ifc.ready), 32'h1);

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the run ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog actual=stalled expected=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
